// File: rtl/rtermcal_pkg.sv
// Shared types and constants for the IO termination-calibration controller.
package rtermcal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_SGIO = 2'b01;
    localparam logic [1:0] MODE_LVDS = 2'b10;

    localparam int              CODE_W   = 4;
    localparam logic [CODE_W-1:0] CODE_MAX = 4'd15;

    // Output bit i carries thermometer position i+1, so code k lights bits 0..k-1.
    function automatic logic [14:0] code2therm(input logic [CODE_W-1:0] code);
        logic [14:0] t;
        for (int i = 0; i < 15; i++) begin
            t[i] = ((i + 1) <= int'(code));
        end
        return t;
    endfunction

endpackage

// File: rtl/rtermcal_sync.sv
// Two-flop synchronizer for the two asynchronous comparator outputs of the cell.
module rtermcal_sync (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [1:0] i_async,
    output logic [1:0] o_sync
);

    logic [1:0] r_meta;
    logic [1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_meta <= 2'b00;
            r_sync <= 2'b00;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/rtermcal_ctrl.sv
// Termination-calibration sequencer: sweeps SGIO then LVDS trim codes and latches the trip code.
// Optional build macro RTERMCAL_VOTE_EN: 2-of-3 majority over three consecutive samples.
module rtermcal_ctrl
    import rtermcal_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic              CLK_I,
    input  logic              RSTN_I,
    input  logic              START_I,
    input  logic [1:0]        SEL_I,
    input  logic [1:0]        RESULT_I,
    output logic [1:0]        MODE_O,
    output logic [14:0]       D_IOSG_O,
    output logic [3:0]        D_LVDS_O,
    output logic [3:0]        SGIO_CODE_O,
    output logic [3:0]        LVDS_CODE_O,
    output logic              BUSY_O,
    output logic              DONE_O,
    output logic [1:0]        ERR_O
);

    state_t              r_state;
    logic                r_leg;          // 0 = SGIO leg active, 1 = LVDS leg active
    logic                r_lvds_sel;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   r_sgio_code;
    logic [CODE_W-1:0]   r_lvds_code;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_err;

    logic [1:0]          w_sync;
    logic                w_res;
    logic                w_decide;
    logic                w_hit;
    logic                w_run;

    rtermcal_sync u_sync (
        .i_clk   (CLK_I),
        .i_rstn  (RSTN_I),
        .i_async (RESULT_I),
        .o_sync  (w_sync)
    );

    assign w_res = r_leg ? w_sync[1] : w_sync[0];

`ifdef RTERMCAL_VOTE_EN
    logic [1:0] r_scnt;
    logic [1:0] r_vote;
    // The third sample is used live; the first two are held in r_vote.
    assign w_decide = (r_scnt == 2'd2);
    assign w_hit    = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_res) | (r_vote[1] & w_res);
`else
    assign w_decide = 1'b1;
    assign w_hit    = w_res;
`endif

    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            r_state     <= ST_IDLE;
            r_leg       <= 1'b0;
            r_lvds_sel  <= 1'b0;
            r_code      <= '0;
            r_sgio_code <= '0;
            r_lvds_code <= '0;
            r_cnt       <= '0;
            r_err       <= 2'b00;
`ifdef RTERMCAL_VOTE_EN
            r_scnt      <= 2'd0;
            r_vote      <= 2'b00;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START_I) begin
                        r_lvds_sel <= SEL_I[1];
                        r_err      <= 2'b00;
                        r_code     <= '0;
                        r_leg      <= ~SEL_I[0];
                        r_state    <= (SEL_I == 2'b00) ? ST_FIN : ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_cnt   <= CNT_W'(SETTLE_CYCLES);
`ifdef RTERMCAL_VOTE_EN
                    r_scnt  <= 2'd0;
`endif
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
`ifdef RTERMCAL_VOTE_EN
                    if (!w_decide) begin
                        r_vote[r_scnt[0]] <= w_res;
                        r_scnt            <= r_scnt + 2'd1;
                    end else
`endif
                    if (w_hit || (r_code == CODE_MAX)) begin
                        if (r_leg) r_lvds_code <= r_code;
                        else       r_sgio_code <= r_code;
                        // Trip at code 0 is under-range; no trip by code 15 is over-range.
                        if (!w_hit || (r_code == '0)) r_err[r_leg] <= 1'b1;
                        if (!r_leg && r_lvds_sel) begin
                            r_leg   <= 1'b1;
                            r_code  <= '0;
                            r_state <= ST_APPLY;
                        end else begin
                            r_state <= ST_FIN;
                        end
                    end else begin
                        r_code  <= r_code + 1'b1;
                        r_state <= ST_APPLY;
                    end
                end
                ST_FIN:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_run = (r_state == ST_APPLY) || (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);

    assign MODE_O      = w_run ? (r_leg ? MODE_LVDS : MODE_SGIO) : MODE_IDLE;
    assign D_IOSG_O    = code2therm((w_run && !r_leg) ? r_code : r_sgio_code);
    assign D_LVDS_O    = (w_run && r_leg) ? r_code : r_lvds_code;
    assign SGIO_CODE_O = r_sgio_code;
    assign LVDS_CODE_O = r_lvds_code;
    assign BUSY_O      = (r_state != ST_IDLE);
    assign DONE_O      = (r_state == ST_FIN);
    assign ERR_O       = r_err;

endmodule
